// File: rtl/sha256_round_ctrl.sv
// Round sequencer for the SHA-256 compression datapath: IDLE -> INIT -> ROUNDS -> DONE.
// Optional abort input is enabled by defining SHA256_CTRL_ABORT_EN.
module sha256_round_ctrl #(
  parameter int NUM_ROUNDS = 64,
  parameter int ROUND_W    = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_init,
  input  logic               i_next,
  input  logic               i_stall,
`ifdef SHA256_CTRL_ABORT_EN
  input  logic               i_abort,
`endif
  output logic               o_ready,
  output logic               o_first_block,
  output logic               o_state_init,
  output logic               o_round_en,
  output logic               o_w_sel_msg,
  output logic [ROUND_W-1:0] o_round_idx,
  output logic               o_digest_update,
  output logic               o_digest_valid
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_INIT   = 2'd1,
    S_ROUNDS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [ROUND_W-1:0] LAST_IDX = ROUND_W'(NUM_ROUNDS - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ROUND_W-1:0] r_round_idx;
  logic [ROUND_W-1:0] w_round_idx_nxt;
  logic               r_first_block;
  logic               w_first_block_nxt;
  logic               r_digest_valid;
  logic               w_digest_valid_nxt;
  logic               w_abort;

`ifdef SHA256_CTRL_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  // State and control registers; reset drops any block in flight without a digest update.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_round_idx    <= '0;
      r_first_block  <= 1'b0;
      r_digest_valid <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_round_idx    <= w_round_idx_nxt;
      r_first_block  <= w_first_block_nxt;
      r_digest_valid <= w_digest_valid_nxt;
    end
  end

  // Next-state logic and combinational strobe decode.
  always_comb begin
    w_state_nxt        = r_state;
    w_round_idx_nxt    = r_round_idx;
    w_first_block_nxt  = r_first_block;
    w_digest_valid_nxt = r_digest_valid;
    o_ready            = 1'b0;
    o_state_init       = 1'b0;
    o_round_en         = 1'b0;
    o_w_sel_msg        = 1'b0;
    o_digest_update    = 1'b0;

    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_init || i_next) begin
          w_first_block_nxt  = i_init;
          w_digest_valid_nxt = 1'b0;
          w_state_nxt        = S_INIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_INIT: begin
        o_state_init    = 1'b1;
        w_round_idx_nxt = '0;
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_ROUNDS;
        end
      end
      S_ROUNDS: begin
        // Rounds 0..15 consume message words directly; later rounds use the schedule.
        o_w_sel_msg = (32'(r_round_idx) < 32'd16);
        if (w_abort) begin
          w_round_idx_nxt = '0;
          w_state_nxt     = S_IDLE;
        end else if (!i_stall) begin
          o_round_en = 1'b1;
          if (r_round_idx == LAST_IDX) begin
            w_round_idx_nxt = '0;
            w_state_nxt     = S_DONE;
          end else begin
            w_round_idx_nxt = r_round_idx + ROUND_W'(1);
          end
        end else begin
          w_state_nxt = S_ROUNDS;
        end
      end
      S_DONE: begin
        o_digest_update    = 1'b1;
        w_digest_valid_nxt = 1'b1;
        w_state_nxt        = S_IDLE;
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_round_idx_nxt = '0;
      end
    endcase
  end

  assign o_round_idx    = r_round_idx;
  assign o_first_block  = r_first_block;
  assign o_digest_valid = r_digest_valid;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench for sha256_round_ctrl: directed scenarios plus random stall/command traffic
// against a step-count reference model (step -1 idle, 0 init, 1..64 rounds, 65 done).
module tb_sha256_round_ctrl;

  localparam int NR = 64;

`ifdef SHA256_CTRL_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       d_reset = 1'b1;
  logic       d_init = 1'b0;
  logic       d_next = 1'b0;
  logic       d_stall = 1'b0;
  logic       d_abort = 1'b0;
  logic       o_ready, o_first_block, o_state_init, o_round_en, o_w_sel_msg;
  logic       o_digest_update, o_digest_valid;
  logic [5:0] o_round_idx;

  sha256_round_ctrl #(.NUM_ROUNDS(NR), .ROUND_W(6)) dut (
    .i_clk          (clk),
    .i_reset        (d_reset),
    .i_init         (d_init),
    .i_next         (d_next),
    .i_stall        (d_stall),
`ifdef SHA256_CTRL_ABORT_EN
    .i_abort        (d_abort),
`endif
    .o_ready        (o_ready),
    .o_first_block  (o_first_block),
    .o_state_init   (o_state_init),
    .o_round_en     (o_round_en),
    .o_w_sel_msg    (o_w_sel_msg),
    .o_round_idx    (o_round_idx),
    .o_digest_update(o_digest_update),
    .o_digest_valid (o_digest_valid)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int m_step  = -1;
  bit m_fb    = 1'b0;
  bit m_dv    = 1'b0;
  bit m_valid = 1'b0;
  bit du_seen = 1'b0;
  int du_cyc  = 0;
  int acc     = 0;
  int prev_du = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: compare outputs against the model, advance the clock, advance the model.
  task automatic step();
    bool_rounds_t: begin end
    #1;
    if (m_valid) begin
      bit in_r;
      int e_idx;
      in_r  = (m_step >= 1) && (m_step <= NR);
      e_idx = in_r ? (m_step - 1) : 0;
      chk("ready",         o_ready,         (m_step == -1));
      chk("state_init",    o_state_init,    (m_step == 0));
      chk("round_en",      o_round_en,      in_r && !d_stall && !(ABORT_EN && d_abort));
      chk("round_idx",     o_round_idx,     e_idx);
      chk("w_sel_msg",     o_w_sel_msg,     in_r && (e_idx < 16));
      chk("digest_update", o_digest_update, (m_step == NR + 1));
      chk("first_block",   o_first_block,   m_fb);
      chk("digest_valid",  o_digest_valid,  m_dv);
    end
    if (o_digest_update === 1'b1) begin
      du_seen = 1'b1;
      du_cyc  = cyc + 1;
    end
    @(posedge clk);
    cyc++;
    if (d_reset) begin
      m_step = -1; m_fb = 1'b0; m_dv = 1'b0; m_valid = 1'b1;
    end else if (m_step == -1) begin
      if (d_init || d_next) begin
        m_fb = d_init; m_dv = 1'b0; m_step = 0;
      end
    end else if (ABORT_EN && d_abort && m_step <= NR) begin
      m_step = -1;
    end else if (m_step <= NR) begin
      if (m_step == 0 || !d_stall) m_step++;
    end else begin
      m_step = -1; m_dv = 1'b1;
    end
    #1;
  endtask

  task automatic wait_idx(input int target);
    for (int k = 0; k < 300 && (m_step - 1) != target; k++) step();
    chk("wait_idx", o_round_idx, target);
  endtask

  task automatic wait_du();
    du_seen = 1'b0;
    for (int k = 0; k < 400 && !du_seen; k++) step();
    chk("du_timeout", du_seen, 1);
  endtask

  initial begin
    @(posedge clk);
    #1;
    // reset
    step(); step();
    d_reset = 1'b0;
    step();
    chk("rst_ready", o_ready, 1);
    chk("rst_dv", o_digest_valid, 0);

    // test 1: init block, no stalls
    d_init = 1'b1; step(); acc = cyc; d_init = 1'b0;
    chk("t1_state_init", o_state_init, 1);
    chk("t1_ready", o_ready, 0);
    wait_du();
    chk("t1_latency", du_cyc - acc, 66);
    chk("t1_ready_after", o_ready, 1);
    chk("t1_dv", o_digest_valid, 1);
    chk("t1_fb", o_first_block, 1);
    prev_du = du_cyc;

    // test 5 / 2: back-to-back next in first idle cycle
    d_next = 1'b1; step(); acc = cyc; d_next = 1'b0;
    chk("t5_dv_clr", o_digest_valid, 0);
    chk("t2_fb_next", o_first_block, 0);
    wait_du();
    chk("t5_gap", du_cyc - prev_du, 67);

    // test 2: init+next together, then init while busy at round 5
    d_init = 1'b1; d_next = 1'b1; step(); acc = cyc; d_init = 1'b0; d_next = 1'b0;
    chk("t2_fb_both", o_first_block, 1);
    wait_idx(5);
    d_init = 1'b1; step(); d_init = 1'b0;
    wait_du();
    chk("t2_busy_latency", du_cyc - acc, 66);

    // test 3: five stalled cycles at round 20
    d_next = 1'b1; step(); acc = cyc; d_next = 1'b0;
    wait_idx(20);
    d_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_hold", o_round_idx, 20);
    end
    d_stall = 1'b0;
    wait_du();
    chk("t3_latency", du_cyc - acc, 71);

    // test 4: reset mid-block
    d_init = 1'b1; step(); d_init = 1'b0;
    wait_idx(30);
    d_reset = 1'b1; step(); d_reset = 1'b0;
    chk("t4_ready", o_ready, 1);
    chk("t4_idx", o_round_idx, 0);
    chk("t4_dv", o_digest_valid, 0);
    du_seen = 1'b0;
    for (int k = 0; k < 70; k++) step();
    chk("t4_no_du", du_seen, 0);

`ifdef SHA256_CTRL_ABORT_EN
    // test 6: abort at round 10
    d_init = 1'b1; step(); d_init = 1'b0;
    wait_idx(10);
    d_abort = 1'b1; step(); d_abort = 1'b0;
    chk("t6_ready", o_ready, 1);
    chk("t6_idx", o_round_idx, 0);
    chk("t6_dv", o_digest_valid, 0);
    du_seen = 1'b0;
    for (int k = 0; k < 70; k++) step();
    chk("t6_no_du", du_seen, 0);
`endif

    // random commands and stalls against the model
    for (int k = 0; k < 1500; k++) begin
      d_stall = ($urandom_range(3) == 0);
      d_init  = ($urandom_range(20) == 0);
      d_next  = ($urandom_range(20) == 0);
      d_abort = ($urandom_range(150) == 0);
      step();
    end
    d_stall = 1'b0; d_init = 1'b0; d_next = 1'b0; d_abort = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
